pipe_stage_reg: RTL

- Parametrised pipeline-stage register that replaces fixed per-stage latches (e.g. MEM/WB) with one reusable block.
- Carries a control field, a destination-register field and a data payload with a valid/ready handshake.
- Includes a 1-entry skid buffer for full throughput under backpressure, a synchronous flush, and a saturating stall counter.
- Sits between any two CPU pipeline stages; downstream sees registered outputs only.

---
 rtl/pipe_stage_reg.sv | 90 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with 1-entry skid buffer, flush and stall counter
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 2,
    parameter int DEST_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DEST_W-1:0] skid_dest;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic drain;
    logic stalled;

    // in_ready comes straight from a flop so there is no path from out_ready
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign stalled  = out_valid && !out_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_dest   <= '0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_dest  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
        end else if (accept && (!out_valid || drain)) begin
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
            out_dest  <= in_dest;
            out_data  <= in_data;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_dest  <= in_dest;
            skid_data  <= in_data;
        end else if (drain && skid_valid) begin
            // refill from the skid slot on the same edge, so no bubble appears
            out_valid  <= 1'b1;
            out_ctrl   <= skid_ctrl;
            out_dest   <= skid_dest;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
        end else if (drain) begin
            // bubble: ctrl zeroed so no write-enable leaks; dest/data hold
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (stalled && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
